// File: rtl/mem_responder.sv
// Memory-side responder: accepts one fetch/load/store request at a time and
// services it from a 1-cycle-latency synchronous BRAM or the memory-mapped IO word.
module mem_responder #(
  parameter int                ADDR_W  = 16,
  parameter int                DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] IO_ADDR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic [15:0]       io_in,
  output logic [15:0]       io_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_next;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;
  logic              hit_io, hit_ram;

  // IO decode wins over RAM decode so the IO word stays reachable even inside the RAM range
  assign hit_io  = (lat_addr == IO_ADDR);
  assign hit_ram = !hit_io && ({1'b0, lat_addr} < DEPTH_EXT);

  assign mem_addr   = lat_addr;
  assign mem_din    = lat_wdata;
  assign resp_valid = (state == RESP);

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        if (hit_ram) begin
          mem_en = 1'b1;
          mem_we = lat_we;
        end
        state_next = (hit_ram && !lat_we) ? CAPT : RESP;
      end
      CAPT: state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset abandons the transaction immediately, including a write about to be issued
    if (reset) begin
      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      io_out     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          // Clearing the response fields here leaves rdata=0 for writes and errors
          if (req_valid) begin
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        ISSUE: begin
          if (hit_io) begin
            if (lat_we) io_out <= lat_wdata;
            else        resp_rdata <= io_in;
          end else if (!hit_ram) begin
            resp_err <= 1'b1;
          end
        end
        CAPT: resp_rdata <= mem_dout;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a behavioural BRAM plus a reference
// model of memory contents, IO register and expected latencies.
module tb_mem_responder;

  localparam int          ADDR_W  = 16;
  localparam int          DEPTH   = 1024;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_din, mem_dout;
  logic [15:0] io_in, io_out;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IO_ADDR(IO_ADDR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .io_in(io_in), .io_out(io_out)
  );

  // Synchronous BRAM with one cycle of read latency
  logic [15:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr[9:0]] <= mem_din;
      else        mem_dout <= bram[mem_addr[9:0]];
    end
  end

  logic [15:0] model_mem [DEPTH];
  logic [15:0] model_io;
  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] r_rdata, r_waddr;
  logic        r_err;
  int          r_lat, r_en, r_we;
  bit          r_stable, r_post;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] pool_addr(input int i);
    return (i < 8) ? 16'(i) : 16'(DEPTH - 16 + i);
  endfunction

  // One complete transaction; results land in the r_* variables
  task automatic run_txn(input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input int hold);
    bit seen;
    int k;
    r_rdata = 16'h0; r_err = 1'b0; r_waddr = 16'h0;
    r_lat = -1; r_en = 0; r_we = 0; r_stable = 1; r_post = 1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    resp_ready = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      r_post = 0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    seen = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_en) r_en++;
      if (mem_en && mem_we) begin
        r_we++;
        r_waddr = mem_addr;
      end
      if (resp_valid) begin
        seen = 1;
        r_lat = c;
        r_rdata = resp_rdata;
        r_err = resp_err;
      end
    end
    if (!seen) begin
      r_post = 0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      if (!resp_valid || resp_rdata !== r_rdata || resp_err !== r_err || req_ready !== 1'b0)
        r_stable = 0;
      if (mem_en) r_en++;
      @(negedge clk);
    end
    if (!resp_valid || resp_rdata !== r_rdata || resp_err !== r_err) r_stable = 0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) r_post = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0;
    req_wdata = 16'h0; resp_ready = 1'b0; io_in = 16'h0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_forced: ready=%b en=%b we=%b required 0 0 0", req_ready, mem_en, mem_we);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
        resp_rdata !== 16'h0 || io_out !== 16'h0 || mem_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b err=%b rdata=%h io_out=%h en=%b required 1 0 0 0000 0000 0",
               req_ready, resp_valid, resp_err, resp_rdata, io_out, mem_en);
    end
    model_io = 16'h0;
  endtask

  task automatic test_write_read;
    run_txn(1'b1, 16'd5, 16'h1234, 0);
    model_mem[5] = 16'h1234;
    tests_run++;
    if (r_we !== 1 || r_en !== 1 || r_waddr !== 16'd5) begin
      tests_failed++;
      $display("[TB] FAIL write_pulse: we_cycles=%0d en_cycles=%0d addr=%0d required 1 1 5", r_we, r_en, r_waddr);
    end
    tests_run++;
    if (r_lat !== 2 || r_rdata !== 16'h0 || r_err !== 1'b0 || !r_post) begin
      tests_failed++;
      $display("[TB] FAIL write_resp: lat=%0d rdata=%h err=%b post=%0d required 2 0000 0 1", r_lat, r_rdata, r_err, r_post);
    end
    run_txn(1'b0, 16'd5, 16'h0, 0);
    tests_run++;
    if (r_lat !== 3 || r_rdata !== 16'h1234 || r_err !== 1'b0 || r_we !== 0) begin
      tests_failed++;
      $display("[TB] FAIL read_back: lat=%0d rdata=%h err=%b we=%0d required 3 1234 0 0", r_lat, r_rdata, r_err, r_we);
    end
  endtask

  task automatic test_io;
    io_in = 16'hA5A5;
    run_txn(1'b0, IO_ADDR, 16'h0, 0);
    tests_run++;
    if (r_rdata !== 16'hA5A5 || r_en !== 0 || r_lat !== 2 || r_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL io_read: rdata=%h en=%0d lat=%0d err=%b required a5a5 0 2 0", r_rdata, r_en, r_lat, r_err);
    end
    run_txn(1'b1, IO_ADDR, 16'h00FF, 0);
    model_io = 16'h00FF;
    tests_run++;
    if (io_out !== 16'h00FF || r_en !== 0 || r_rdata !== 16'h0 || r_lat !== 2) begin
      tests_failed++;
      $display("[TB] FAIL io_write: io_out=%h en=%0d rdata=%h lat=%0d required 00ff 0 0000 2", io_out, r_en, r_rdata, r_lat);
    end
  endtask

  task automatic test_error;
    run_txn(1'b0, 16'(DEPTH), 16'h0, 0);
    tests_run++;
    if (r_err !== 1'b1 || r_rdata !== 16'h0 || r_en !== 0 || r_lat !== 2) begin
      tests_failed++;
      $display("[TB] FAIL err_read: err=%b rdata=%h en=%0d lat=%0d required 1 0000 0 2", r_err, r_rdata, r_en, r_lat);
    end
    run_txn(1'b1, 16'hFFFE, 16'hBEEF, 0);
    tests_run++;
    if (r_err !== 1'b1 || r_en !== 0 || io_out !== model_io) begin
      tests_failed++;
      $display("[TB] FAIL err_write: err=%b en=%0d io_out=%h required 1 0 %h", r_err, r_en, io_out, model_io);
    end
    run_txn(1'b0, 16'd5, 16'h0, 0);
    tests_run++;
    if (r_err !== 1'b0 || r_rdata !== model_mem[5]) begin
      tests_failed++;
      $display("[TB] FAIL err_cleared: err=%b rdata=%h required 0 %h", r_err, r_rdata, model_mem[5]);
    end
  endtask

  task automatic test_backpressure;
    run_txn(1'b0, 16'd5, 16'h0, 5);
    tests_run++;
    if (!r_stable || !r_post || r_rdata !== model_mem[5] || r_en !== 1) begin
      tests_failed++;
      $display("[TB] FAIL backpressure: stable=%0d post=%0d rdata=%h en=%0d required 1 1 %h 1",
               r_stable, r_post, r_rdata, r_en, model_mem[5]);
    end
    run_txn(1'b1, 16'd6, 16'h0606, 0);
    model_mem[6] = 16'h0606;
    tests_run++;
    if (r_lat !== 2 || r_we !== 1 || r_waddr !== 16'd6) begin
      tests_failed++;
      $display("[TB] FAIL after_release: lat=%0d we=%0d addr=%0d required 2 1 6", r_lat, r_we, r_waddr);
    end
  endtask

  task automatic test_fill;
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      run_txn(1'b1, pool_addr(i), d, 0);
      model_mem[pool_addr(i)] = d;
      if (r_we !== 1 || r_waddr !== pool_addr(i) || r_lat !== 2) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL fill_writes: bad_writes=%0d required 0", bad);
    end
  endtask

  task automatic test_reset_midflight;
    bit glitch = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd7; req_wdata = ~model_mem[7];
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we !== 1'b0 || mem_en !== 1'b0 || resp_valid !== 1'b0) glitch = 1;
    end
    reset = 1'b0;
    model_io = 16'h0;
    tests_run++;
    if (glitch) begin
      tests_failed++;
      $display("[TB] FAIL reset_abort: en/we/valid seen during reset, required none");
    end
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || io_out !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_recover: ready=%b valid=%b io_out=%h required 1 0 0000", req_ready, resp_valid, io_out);
    end
    run_txn(1'b0, 16'd7, 16'h0, 0);
    tests_run++;
    if (r_rdata !== model_mem[7] || r_lat !== 3) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_write: rdata=%h lat=%0d required %h 3", r_rdata, r_lat, model_mem[7]);
    end
  endtask

  task automatic test_back_to_back;
    int acc_cyc[$];
    logic [15:0] exp_q[$];
    logic [15:0] want;
    int bad_data = 0;
    int bad_gap = 0;
    bit acc;
    @(negedge clk);
    resp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    req_addr = pool_addr($urandom_range(0, 15));
    for (int c = 0; c < 26; c++) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) bad_data++;
        else begin
          want = exp_q.pop_front();
          if (resp_rdata !== want || resp_err !== 1'b0) bad_data++;
        end
      end
      acc = req_ready;
      if (acc) begin
        acc_cyc.push_back(c);
        exp_q.push_back(model_mem[req_addr[9:0]]);
      end
      @(posedge clk); #1;
      if (acc) req_addr = pool_addr($urandom_range(0, 15));
      if (c == 25) req_valid = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      if (resp_valid) begin
        want = exp_q.pop_front();
        if (resp_rdata !== want) bad_data++;
      end
      @(negedge clk);
    end
    resp_ready = 1'b0;
    for (int i = 1; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-1] != 4) bad_gap++;
    tests_run++;
    if (acc_cyc.size() != 7 || bad_gap != 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_throughput: accepts=%0d bad_gaps=%0d required 7 0", acc_cyc.size(), bad_gap);
    end
    tests_run++;
    if (bad_data != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_data: bad=%0d left=%0d required 0 0", bad_data, exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic        we;
    logic [15:0] addr, wdata, exp_rdata;
    logic        is_io, is_ram, exp_err;
    int          exp_lat, hold;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    addr = pool_addr($urandom_range(0, 15));
        2:       addr = 16'(DEPTH);
        3:       addr = IO_ADDR;
        4:       addr = 16'($urandom_range(DEPTH + 1, 65534));
        default: addr = 16'(DEPTH - 1);
      endcase
      we    = 1'($urandom);
      wdata = 16'($urandom);
      hold  = $urandom_range(0, 3);
      io_in = 16'($urandom);
      is_io  = (addr == IO_ADDR);
      is_ram = !is_io && (int'(addr) < DEPTH);
      exp_err = !is_io && !is_ram;
      exp_lat = (is_ram && !we) ? 3 : 2;
      if (we || exp_err)  exp_rdata = 16'h0;
      else if (is_io)     exp_rdata = io_in;
      else                exp_rdata = model_mem[addr[9:0]];
      run_txn(we, addr, wdata, hold);
      if (is_ram && we) model_mem[addr[9:0]] = wdata;
      if (is_io && we)  model_io = wdata;
      tests_run++;
      if (r_rdata !== exp_rdata || r_err !== exp_err || r_lat !== exp_lat) begin
        tests_failed++;
        $display("[TB] FAIL rand_resp[%0d]: addr=%h we=%b rdata=%h err=%b lat=%0d required %h %b %0d",
                 n, addr, we, r_rdata, r_err, r_lat, exp_rdata, exp_err, exp_lat);
      end
      tests_run++;
      if (r_en !== (is_ram ? 1 : 0) || r_we !== ((is_ram && we) ? 1 : 0)) begin
        tests_failed++;
        $display("[TB] FAIL rand_mem[%0d]: addr=%h en=%0d we=%0d required %0d %0d",
                 n, addr, r_en, r_we, is_ram ? 1 : 0, (is_ram && we) ? 1 : 0);
      end
      tests_run++;
      if (!r_stable || !r_post || io_out !== model_io) begin
        tests_failed++;
        $display("[TB] FAIL rand_hs[%0d]: stable=%0d post=%0d io_out=%h required 1 1 %h",
                 n, r_stable, r_post, io_out, model_io);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_io();
    test_error();
    test_backpressure();
    test_fill();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
